pmp_arbiter: RTL and testbench

Shares the single combinational PMP checker (`mpu`) between the instruction-fetch and load/store requesters. Arbitrates each cycle and drives the checker address from a registered stage. Turns the checker's match/permission outputs into a per-requester allow/fault response two cycles after acceptance, at one check per cycle. Blocks new checks around PMP CSR writes and keeps a fault address and a saturating fault counter for debug.

---
 rtl/pmp_arbiter.sv | 168 ++++++++++++++++
 tb/tb_pmp_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_arbiter.sv
// Shares one combinational PMP checker between fetch and load/store requesters.
// Three stages: accept/arbitrate, check against the checker, registered response.
module pmp_arbiter #(
    parameter int PADDR_LEN = 34,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [PADDR_LEN-1:0] if_req_addr,
    input  logic                 if_priv_m,

    input  logic                 ls_req_valid,
    output logic                 ls_req_ready,
    input  logic [PADDR_LEN-1:0] ls_req_addr,
    input  logic                 ls_req_wr,
    input  logic                 ls_priv_m,

    output logic                 if_rsp_valid,
    output logic                 if_rsp_fault,
    output logic                 ls_rsp_valid,
    output logic                 ls_rsp_fault,

    output logic [PADDR_LEN-1:0] mpu_paddr,
    input  logic                 mpu_v,
    input  logic                 mpu_l,
    input  logic                 mpu_x,
    input  logic                 mpu_w,
    input  logic                 mpu_r,
    input  logic                 pmp_any_en,

    input  logic                 cfg_busy,

    output logic [PADDR_LEN-1:0] fault_addr,
    output logic [CNT_W-1:0]     fault_cnt,
    input  logic                 cnt_clr
);

    // Requester index 0 = fetch, 1 = load/store.
    localparam int N_REQ = 2;

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     hs;
    logic                 accept;
    logic                 blocked;

    logic                 last_grant_reg;
    logic                 busy_d_reg;

    logic                 vld_b_reg;
    logic [PADDR_LEN-1:0] addr_q_reg;
    logic                 owner_q_reg;
    logic                 wr_q_reg;
    logic                 priv_q_reg;

    logic                 perm;
    logic                 allow;
    logic                 fault_b;

    logic [N_REQ-1:0]     rsp_valid_reg;
    logic [N_REQ-1:0]     rsp_fault_reg;
    logic [PADDR_LEN-1:0] fault_addr_reg;
    logic [CNT_W-1:0]     fault_cnt_reg;
    logic [CNT_W-1:0]     fault_cnt_next;

    assign req_valid = {ls_req_valid, if_req_valid};

    // On a tie the requester that did not win the last handshake goes first.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_grant_reg ? 2'b01 : 2'b10;
        end
    end

    // The delayed busy flag stretches the block one cycle past cfg_busy falling.
    assign blocked   = cfg_busy | busy_d_reg;
    assign req_ready = (rst | blocked) ? '0 : grant;
    assign hs        = req_ready & req_valid;
    assign accept    = |hs;

    assign if_req_ready = req_ready[0];
    assign ls_req_ready = req_ready[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_d_reg     <= 1'b0;
            last_grant_reg <= 1'b0;
            vld_b_reg      <= 1'b0;
            addr_q_reg     <= '0;
            owner_q_reg    <= 1'b0;
            wr_q_reg       <= 1'b0;
            priv_q_reg     <= 1'b0;
        end else begin
            busy_d_reg <= cfg_busy;
            vld_b_reg  <= accept;
            if (accept) begin
                last_grant_reg <= hs[1];
                owner_q_reg    <= hs[1];
                addr_q_reg     <= hs[1] ? ls_req_addr : if_req_addr;
                wr_q_reg       <= hs[1] & ls_req_wr;
                priv_q_reg     <= hs[1] ? ls_priv_m : if_priv_m;
            end
        end
    end

    assign mpu_paddr = addr_q_reg;

    always_comb begin
        perm = owner_q_reg ? (wr_q_reg ? mpu_w : mpu_r) : mpu_x;
        if (mpu_v) begin
            allow = (priv_q_reg & ~mpu_l) | perm;
        end else begin
            allow = priv_q_reg | ~pmp_any_en;
        end
    end

    assign fault_b = vld_b_reg & ~allow;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid_reg[gi] <= 1'b0;
                    rsp_fault_reg[gi] <= 1'b0;
                end else begin
                    rsp_valid_reg[gi] <= vld_b_reg & (owner_q_reg == 1'(gi));
                    rsp_fault_reg[gi] <= fault_b & (owner_q_reg == 1'(gi));
                end
            end
        end
    endgenerate

    assign if_rsp_valid = rsp_valid_reg[0];
    assign if_rsp_fault = rsp_fault_reg[0];
    assign ls_rsp_valid = rsp_valid_reg[1];
    assign ls_rsp_fault = rsp_fault_reg[1];

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        fault_cnt_next = fault_cnt_reg;
        if (cnt_clr) begin
            fault_cnt_next = '0;
        end else if (fault_b && !(&fault_cnt_reg)) begin
            fault_cnt_next = fault_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_addr_reg <= '0;
            fault_cnt_reg  <= '0;
        end else begin
            fault_cnt_reg <= fault_cnt_next;
            if (fault_b) begin
                fault_addr_reg <= addr_q_reg;
            end
        end
    end

    assign fault_addr = fault_addr_reg;
    assign fault_cnt  = fault_cnt_reg;

endmodule

// File: tb/tb_pmp_arbiter.sv
// Scoreboard bench for pmp_arbiter: directed per-cycle vectors push expected
// responses; a separate monitor pops and checks each response pulse.
module tb_pmp_arbiter;

    localparam int PADDR_LEN = 34;
    localparam int CNT_W     = 8;

    localparam logic [PADDR_LEN-1:0] A_UNMAP = 34'h0_8000_0000;
    localparam logic [PADDR_LEN-1:0] A_RO    = 34'h0_1000_0000;
    localparam logic [PADDR_LEN-1:0] A_LK    = 34'h0_2000_0000;
    localparam logic [PADDR_LEN-1:0] A_RW    = 34'h0_3000_0000;
    localparam logic [PADDR_LEN-1:0] A_RX    = 34'h0_4000_0000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 if_req_valid = 1'b0;
    logic                 if_req_ready;
    logic [PADDR_LEN-1:0] if_req_addr = '0;
    logic                 if_priv_m = 1'b0;
    logic                 ls_req_valid = 1'b0;
    logic                 ls_req_ready;
    logic [PADDR_LEN-1:0] ls_req_addr = '0;
    logic                 ls_req_wr = 1'b0;
    logic                 ls_priv_m = 1'b0;
    logic                 if_rsp_valid, if_rsp_fault, ls_rsp_valid, ls_rsp_fault;
    logic [PADDR_LEN-1:0] mpu_paddr;
    logic                 mpu_v, mpu_l, mpu_x, mpu_w, mpu_r;
    logic                 pmp_any_en = 1'b1;
    logic                 cfg_busy = 1'b0;
    logic [PADDR_LEN-1:0] fault_addr;
    logic [CNT_W-1:0]     fault_cnt;
    logic                 cnt_clr = 1'b0;

    pmp_arbiter #(.PADDR_LEN(PADDR_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr), .if_priv_m(if_priv_m),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
        .ls_req_addr(ls_req_addr), .ls_req_wr(ls_req_wr), .ls_priv_m(ls_priv_m),
        .if_rsp_valid(if_rsp_valid), .if_rsp_fault(if_rsp_fault),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_fault(ls_rsp_fault),
        .mpu_paddr(mpu_paddr),
        .mpu_v(mpu_v), .mpu_l(mpu_l), .mpu_x(mpu_x), .mpu_w(mpu_w), .mpu_r(mpu_r),
        .pmp_any_en(pmp_any_en), .cfg_busy(cfg_busy),
        .fault_addr(fault_addr), .fault_cnt(fault_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    // Stand-in PMP checker: fixed regions keyed by address.
    always_comb begin
        {mpu_v, mpu_l, mpu_x, mpu_w, mpu_r} = 5'b00000;
        case (mpu_paddr)
            A_RO:    {mpu_v, mpu_l, mpu_x, mpu_w, mpu_r} = 5'b10001;
            A_LK:    {mpu_v, mpu_l, mpu_x, mpu_w, mpu_r} = 5'b11011;
            A_RW:    {mpu_v, mpu_l, mpu_x, mpu_w, mpu_r} = 5'b10011;
            A_RX:    {mpu_v, mpu_l, mpu_x, mpu_w, mpu_r} = 5'b10101;
            default: {mpu_v, mpu_l, mpu_x, mpu_w, mpu_r} = 5'b00000;
        endcase
    end

    typedef struct {
        logic                 owner;
        logic                 fault;
        logic [PADDR_LEN-1:0] addr;
        int                   due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one line per response, compared against the scoreboard head.
    always @(negedge clk) begin
        if (if_rsp_valid === 1'b1 || ls_rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: if_v=%b ls_v=%b with empty scoreboard (cycle %0d)",
                         if_rsp_valid, ls_rsp_valid, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("rsp cycle %0d: owner=%s fault=%b addr=%0h",
                         cyc, e.owner ? "LS" : "IF", e.owner ? ls_rsp_fault : if_rsp_fault, e.addr);
                chk("rsp_owner", {62'd0, ls_rsp_valid, if_rsp_valid}, e.owner ? 64'd2 : 64'd1);
                chk("rsp_fault", {63'd0, e.owner ? ls_rsp_fault : if_rsp_fault}, {63'd0, e.fault});
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                if (e.fault) chk("fault_addr", 64'(fault_addr), 64'(e.addr));
            end
        end
    end

    // One cycle of stimulus: apply after the edge, check readies mid-cycle,
    // and push the expected response for whichever handshake actually happened.
    task automatic drive(input logic r,
                         input logic ifv, input logic [PADDR_LEN-1:0] ifa, input logic ifpm,
                         input logic lsv, input logic [PADDR_LEN-1:0] lsa, input logic lswr,
                         input logic lspm, input logic busy, input logic clr,
                         input logic exp_ifr, input logic exp_lsr,
                         input logic exp_iff, input logic exp_lsf);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; if_req_valid = ifv; if_req_addr = ifa; if_priv_m = ifpm;
        ls_req_valid = lsv; ls_req_addr = lsa; ls_req_wr = lswr; ls_priv_m = lspm;
        cfg_busy = busy; cnt_clr = clr;
        @(negedge clk);
        chk("if_req_ready", {63'd0, if_req_ready}, {63'd0, exp_ifr});
        chk("ls_req_ready", {63'd0, ls_req_ready}, {63'd0, exp_lsr});
        if (if_req_ready && ifv) begin
            e.owner = 1'b0; e.fault = exp_iff; e.addr = ifa; e.due = cyc + 2;
            sb.push_back(e);
            $display("req cycle %0d: IF accepted addr=%0h", cyc, ifa);
        end
        if (ls_req_ready && lsv) begin
            e.owner = 1'b1; e.fault = exp_lsf; e.addr = lsa; e.due = cyc + 2;
            sb.push_back(e);
            $display("req cycle %0d: LS accepted addr=%0h wr=%b", cyc, lsa, lswr);
        end
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0,
                                          1'b0, clr, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic if_req(input logic [PADDR_LEN-1:0] a, input logic pm, input logic f);
        drive(1'b0, 1'b1, a, pm, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f, 1'b0);
    endtask

    task automatic ls_req(input logic [PADDR_LEN-1:0] a, input logic wr, input logic pm,
                          input logic f);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, a, wr, pm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_if_rsp_valid"}, {63'd0, if_rsp_valid}, 64'd0);
        chk({tag, "_ls_rsp_valid"}, {63'd0, ls_rsp_valid}, 64'd0);
        chk({tag, "_rsp_faults"}, {62'd0, if_rsp_fault, ls_rsp_fault}, 64'd0);
        chk({tag, "_mpu_paddr"}, 64'(mpu_paddr), 64'd0);
        chk({tag, "_fault_addr"}, 64'(fault_addr), 64'd0);
        chk({tag, "_fault_cnt"}, 64'(fault_cnt), 64'd0);
    endtask

    // Tie phase: {cfg_busy, expected IF ready, expected LS ready} per cycle.
    logic [2:0] tie_vec [11] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001,
                                 3'b100, 3'b100, 3'b100, 3'b000, 3'b010, 3'b001};

    initial begin
        // Reset with requests pending: readies held low, everything zero.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, A_RX, 1'b0, 1'b1, A_RO, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0);
        check_quiet("reset");

        // Both valid from reset: LS, IF, LS, IF, LS; cfg_busy high in 5..7 blocks 5..8.
        for (int c = 0; c < 11; c++) begin
            logic [2:0] v;
            v = tie_vec[c];
            drive(1'b0, 1'b1, A_RX, 1'b0, 1'b1, A_RO, 1'b0, 1'b0, v[2], 1'b0,
                  v[1], v[0], 1'b0, 1'b0);
        end
        idle(2, 1'b0);

        // M-mode fetch, no matching region, PMP enabled: allowed; address reaches checker next cycle.
        if_req(A_UNMAP, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("mpu_paddr_n1", 64'(mpu_paddr), 64'(A_UNMAP));
        idle(2, 1'b0);
        chk("mpu_paddr_hold", 64'(mpu_paddr), 64'(A_UNMAP));

        // U-mode store to read-only region faults and logs; the load is fine.
        ls_req(A_RO, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);
        chk("fault_cnt_1", 64'(fault_cnt), 64'd1);
        chk("fault_addr_store", 64'(fault_addr), 64'(A_RO));
        ls_req(A_RO, 1'b0, 1'b0, 1'b0);
        ls_req(A_RW, 1'b1, 1'b0, 1'b0);

        // M-mode fetch: locked no-exec faults, unlocked no-exec is allowed.
        if_req(A_LK, 1'b1, 1'b1);
        if_req(A_RW, 1'b1, 1'b0);
        idle(2, 1'b0);
        chk("fault_cnt_2", 64'(fault_cnt), 64'd2);
        chk("fault_addr_lk", 64'(fault_addr), 64'(A_LK));

        // No match in U-mode: allowed only when no entry is enabled.
        pmp_any_en = 1'b0;
        if_req(A_UNMAP, 1'b0, 1'b0);
        idle(2, 1'b0);
        pmp_any_en = 1'b1;
        if_req(A_UNMAP, 1'b0, 1'b1);
        idle(2, 1'b0);
        chk("fault_cnt_3", 64'(fault_cnt), 64'd3);

        // 260 back-to-back faults saturate the counter at 255.
        for (int i = 0; i < 260; i++) if_req(A_LK, 1'b0, 1'b1);
        idle(2, 1'b0);
        chk("fault_cnt_sat", 64'(fault_cnt), 64'd255);
        idle(1, 1'b0);
        chk("fault_cnt_hold", 64'(fault_cnt), 64'd255);

        // Clear in the same cycle as a stage-B fault wins.
        if_req(A_LK, 1'b0, 1'b1);
        idle(1, 1'b1);
        idle(2, 1'b0);
        chk("fault_cnt_clr", 64'(fault_cnt), 64'd0);
        ls_req(A_RX, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);
        chk("fault_cnt_after_clr", 64'(fault_cnt), 64'd1);

        // Reset while one check sits in C and another in B: the B one is dropped.
        if_req(A_LK, 1'b0, 1'b1);
        ls_req(A_RO, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, A_RX, 1'b0, 1'b1, A_RO, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        #1;
        chk("dropped_in_flight", 64'(sb.size()), 64'd1);
        sb.delete();
        check_quiet("midflight_reset");
        idle(3, 1'b0);
        check_quiet("after_reset");

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
